// File: rtl/data_reader_accum_pkg.sv
// Shared definitions for data_reader_accum: default widths, accumulator width
// and the frame FSM state encoding.
package data_reader_accum_pkg;

  localparam int unsigned DWIDTH_DEF    = 32;
  localparam int unsigned CNT_WIDTH_DEF = 7;
  localparam int unsigned SUM_W         = DWIDTH_DEF + CNT_WIDTH_DEF;

  // IDLE: waiting for a frame, ACC: summing a frame,
  // HOLD: result offered, DROP: result offered while a frame is discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/data_reader_accum_valid_delay_line.sv
// Delays the BRAM enable (run_i) by the read latency so the resulting vld
// lines up with the q data it qualifies.
//  clk, rst : clock, asynchronous active-high reset
//  run_i    : BRAM enable from data_reader
//  vld_o    : run_i delayed RD_LATENCY cycles
//  busy_o   : at least one read still travelling through the delay line
module data_reader_accum_valid_delay_line #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic vld_o,
  output logic busy_o
);

  logic [RD_LATENCY-1:0] sr;

  // Shift register; bit 0 is the most recent run_i sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | RD_LATENCY'(run_i);
  end

  assign vld_o  = sr[RD_LATENCY-1];
  assign busy_o = |sr;

endmodule

// File: rtl/data_reader_accum.sv
// Consumes the data_reader BRAM stream and reduces each read burst (frame) to
// sum, sample count and unsigned max, offered on a valid/ready result port.
// The upstream cannot stall, so a frame arriving while a result is still
// unaccepted is discarded and flagged on the sticky lost_o.
//  clk, rst         : clock, asynchronous active-high reset
//  run_i, q_i       : data_reader BRAM enable and read data
//  res_ready_i      : consumer accepts the held result
//  clr_lost_i       : clears lost_o (a simultaneous new drop wins)
//  res_valid_o      : result held and valid
//  res_sum_o/cnt/max: frame sum, sample count, largest sample
//  idle_o           : IDLE with no read in flight
//  lost_o           : at least one frame dropped
module data_reader_accum
  import data_reader_accum_pkg::*;
#(
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run_i,
  input  logic [DWIDTH-1:0]           q_i,
  input  logic                        res_ready_i,
  input  logic                        clr_lost_i,
  output logic                        res_valid_o,
  output logic [DWIDTH+CNT_WIDTH-1:0] res_sum_o,
  output logic [CNT_WIDTH-1:0]        res_cnt_o,
  output logic [DWIDTH-1:0]           res_max_o,
  output logic                        idle_o,
  output logic                        lost_o
);

  // Sized so a full-length frame of all-ones samples cannot overflow
  localparam int unsigned ACC_W = DWIDTH + CNT_WIDTH;

  state_t               state;
  logic                 vld;
  logic                 busy;
  logic [ACC_W-1:0]     acc_sum;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic [DWIDTH-1:0]    acc_max;

  data_reader_accum_valid_delay_line #(
    .RD_LATENCY (RD_LATENCY)
  ) u_vdl (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_i),
    .vld_o  (vld),
    .busy_o (busy)
  );

  // Decoded from flops only: no input-to-output path
  assign idle_o = (state == ST_IDLE) && !busy;

  // Frame FSM, accumulators and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc_sum     <= '0;
      acc_cnt     <= '0;
      acc_max     <= '0;
      res_valid_o <= 1'b0;
      res_sum_o   <= '0;
      res_cnt_o   <= '0;
      res_max_o   <= '0;
      lost_o      <= 1'b0;
    end else begin
      // A drop later in this block overrides the clear
      if (clr_lost_i) lost_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (vld) begin
            acc_sum <= ACC_W'(q_i);
            acc_cnt <= CNT_WIDTH'(1);
            acc_max <= q_i;
            state   <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (vld) begin
            acc_sum <= acc_sum + ACC_W'(q_i);
            acc_cnt <= acc_cnt + CNT_WIDTH'(1);
            if (q_i > acc_max) acc_max <= q_i;
          end else begin
            res_sum_o   <= acc_sum;
            res_cnt_o   <= acc_cnt;
            res_max_o   <= acc_max;
            res_valid_o <= 1'b1;
            state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            // A sample arriving on the accept cycle opens the next frame
            if (vld) begin
              acc_sum <= ACC_W'(q_i);
              acc_cnt <= CNT_WIDTH'(1);
              acc_max <= q_i;
              state   <= ST_ACC;
            end else begin
              state   <= ST_IDLE;
            end
          end else if (vld) begin
            lost_o <= 1'b1;
            state  <= ST_DROP;
          end
        end

        ST_DROP: begin
          if (res_ready_i) res_valid_o <= 1'b0;
          // Discard the rest of the frame even after the result is taken
          if (!vld) begin
            if (res_valid_o && !res_ready_i) state <= ST_HOLD;
            else                             state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_reader_accum.sv
// Bench for data_reader_accum: models data_reader (q = data paired with a run
// cycle, presented RD_LATENCY cycles later) and compares every cycle against a
// frame-level reference model built on a sample queue.
module tb_data_reader_accum;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 7;
  localparam int unsigned RL = 2;
  localparam int unsigned SW = DW + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_i;
  logic [DW-1:0] q_i;
  logic          res_ready_i;
  logic          clr_lost_i;
  logic          res_valid_o;
  logic [SW-1:0] res_sum_o;
  logic [CW-1:0] res_cnt_o;
  logic [DW-1:0] res_max_o;
  logic          idle_o;
  logic          lost_o;

  always #5 clk = ~clk;

  data_reader_accum #(
    .DWIDTH     (DW),
    .CNT_WIDTH  (CW),
    .RD_LATENCY (RL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_i),
    .q_i         (q_i),
    .res_ready_i (res_ready_i),
    .clr_lost_i  (clr_lost_i),
    .res_valid_o (res_valid_o),
    .res_sum_o   (res_sum_o),
    .res_cnt_o   (res_cnt_o),
    .res_max_o   (res_max_o),
    .idle_o      (idle_o),
    .lost_o      (lost_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit                hr[RL];    // run history, index 0 = previous cycle
  logic [DW-1:0]     hd[RL];    // data paired with each run cycle
  logic [DW-1:0]     frame[$];
  bit                in_frame, dropping, m_valid, m_lost, m_idle;
  longint unsigned   m_sum;
  int                m_cnt;
  logic [DW-1:0]     m_max;

  task automatic model_reset();
    for (int i = 0; i < RL; i++) begin hr[i] = 1'b0; hd[i] = '0; end
    frame.delete();
    in_frame = 0; dropping = 0; m_valid = 0; m_lost = 0; m_idle = 1;
    m_sum = 0; m_cnt = 0; m_max = '0;
  endtask

  task automatic model_step(input bit vld, input logic [DW-1:0] q,
                            input bit ready, input bit clr);
    if (m_valid && ready) m_valid = 0;
    if (clr) m_lost = 0;
    if (vld) begin
      if (in_frame) frame.push_back(q);
      else if (!dropping) begin
        if (m_valid) begin dropping = 1; m_lost = 1; end
        else begin frame.delete(); frame.push_back(q); in_frame = 1; end
      end
    end else begin
      if (in_frame) begin
        m_valid = 1;
        m_cnt   = frame.size();
        m_sum   = 0;
        m_max   = '0;
        foreach (frame[i]) begin
          m_sum += longint'(frame[i]);
          if (frame[i] > m_max) m_max = frame[i];
        end
        in_frame = 0;
      end
      dropping = 0;
    end
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge
  task automatic tick(input bit run, input logic [DW-1:0] data,
                      input bit ready, input bit clr);
    bit            vld;
    logic [DW-1:0] qv;
    vld = hr[RL-1];
    qv  = hd[RL-1];
    run_i       = run;
    q_i         = vld ? qv : DW'($urandom);
    res_ready_i = ready;
    clr_lost_i  = clr;
    model_step(vld, qv, ready, clr);
    for (int i = RL - 1; i > 0; i--) begin hr[i] = hr[i-1]; hd[i] = hd[i-1]; end
    hr[0] = run;
    hd[0] = data;
    m_idle = !m_valid && !in_frame && !dropping;
    for (int i = 0; i < RL; i++) if (hr[i]) m_idle = 0;
    @(negedge clk);
    chk("res_valid", 64'(res_valid_o), 64'(m_valid));
    if (m_valid) begin
      chk("res_sum", 64'(res_sum_o), m_sum);
      chk("res_cnt", 64'(res_cnt_o), 64'(m_cnt));
      chk("res_max", 64'(res_max_o), 64'(m_max));
    end
    chk("lost", 64'(lost_o), 64'(m_lost));
    chk("idle", 64'(idle_o), 64'(m_idle));
  endtask

  task automatic idle_ticks(input int n, input bit ready);
    for (int i = 0; i < n; i++) tick(1'b0, '0, ready, 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must clear asynchronously
  task automatic do_reset();
    run_i = 1'b0; res_ready_i = 1'b0; clr_lost_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_sum",   64'(res_sum_o),   64'd0);
    chk("rst_cnt",   64'(res_cnt_o),   64'd0);
    chk("rst_max",   64'(res_max_o),   64'd0);
    chk("rst_lost",  64'(lost_o),      64'd0);
    chk("rst_idle",  64'(idle_o),      64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int rem;
    int gap;
    bit run;
    logic [DW-1:0] data;

    rst = 1'b1; run_i = 1'b0; q_i = '0; res_ready_i = 1'b0; clr_lost_i = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: reset with three samples accumulated
    for (int i = 0; i < int'(RL) + 3; i++) tick(1'b1, DW'(i + 1), 1'b1, 1'b0);
    do_reset();
    idle_ticks(RL + 3, 1'b0);
    chk("s1_no_result", 64'(res_valid_o), 64'd0);

    // 2: five samples 1..5, ready high; check rise latency
    for (int i = 0; i < 5; i++) tick(1'b1, DW'(i + 1), 1'b1, 1'b0);
    n = 0;
    do begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n++;
    end while (!res_valid_o && n < 20);
    chk("s2_latency", 64'(n), 64'(RL + 1));
    chk("s2_sum", 64'(res_sum_o), 64'd15);
    chk("s2_cnt", 64'(res_cnt_o), 64'd5);
    chk("s2_max", 64'(res_max_o), 64'd5);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("s2_pulse", 64'(res_valid_o), 64'd0);
    idle_ticks(3, 1'b0);

    // 3: {7,200,3} held for ten cycles, then accepted
    tick(1'b1, DW'(7),   1'b0, 1'b0);
    tick(1'b1, DW'(200), 1'b0, 1'b0);
    tick(1'b1, DW'(3),   1'b0, 1'b0);
    idle_ticks(10, 1'b0);
    chk("s3_sum", 64'(res_sum_o), 64'd210);
    chk("s3_max", 64'(res_max_o), 64'd200);
    chk("s3_cnt", 64'(res_cnt_o), 64'd3);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("s3_valid", 64'(res_valid_o), 64'd0);
    chk("s3_idle",  64'(idle_o),      64'd1);

    // 4: frame arrives while holding; clear on the drop cycle loses to set
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(i + 1), 1'b0, 1'b0);
    idle_ticks(4, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, DW'(i + 50), 1'b0, i == int'(RL));
    idle_ticks(4, 1'b0);
    chk("s4_lost",  64'(lost_o),    64'd1);
    chk("s4_sum",   64'(res_sum_o), 64'd10);
    chk("s4_cnt",   64'(res_cnt_o), 64'd4);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("s4_clr",   64'(lost_o),    64'd0);
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_ticks(2, 1'b0);

    // 5: accept on the next frame's first valid sample
    tick(1'b1, DW'(5), 1'b0, 1'b0);
    tick(1'b1, DW'(6), 1'b0, 1'b0);
    idle_ticks(4, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(i + 1), i == int'(RL), 1'b0);
    idle_ticks(RL + 2, 1'b0);
    chk("s5_lost",  64'(lost_o),      64'd0);
    chk("s5_valid", 64'(res_valid_o), 64'd1);
    chk("s5_cnt",   64'(res_cnt_o),   64'd6);
    chk("s5_sum",   64'(res_sum_o),   64'd21);
    tick(1'b0, '0, 1'b1, 1'b0);

    // 6: full-length all-ones frame, then a single sample
    for (int i = 0; i < 127; i++) tick(1'b1, '1, 1'b0, 1'b0);
    idle_ticks(RL + 2, 1'b0);
    chk("s6_cnt", 64'(res_cnt_o), 64'd127);
    chk("s6_sum", 64'(res_sum_o), 64'd127 * 64'hFFFF_FFFF);
    chk("s6_max", 64'(res_max_o), 64'hFFFF_FFFF);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, DW'(9), 1'b0, 1'b0);
    idle_ticks(RL + 2, 1'b0);
    chk("s6b_cnt", 64'(res_cnt_o), 64'd1);
    chk("s6b_sum", 64'(res_sum_o), 64'd9);
    chk("s6b_max", 64'(res_max_o), 64'd9);
    tick(1'b0, '0, 1'b1, 1'b0);

    // Random bursts, gaps, ready and clear
    rem = 0;
    gap = 0;
    repeat (1500) begin
      if (rem == 0 && gap == 0) rem = $urandom_range(1, 30);
      if (rem > 0) begin
        run = 1'b1;
        rem--;
        if (rem == 0) gap = $urandom_range(1, 8);
      end else begin
        run = 1'b0;
        gap--;
      end
      data = ($urandom_range(0, 3) == 0) ? '1 : DW'($urandom);
      tick(run, data, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    // Reset while a result may be held
    do_reset();
    idle_ticks(RL + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
